// File: rtl/gb_stream_pkg.sv
// Shared definitions for the ghostbus byte-stream master.
// The optional write acknowledge is controlled by GB_STREAM_WACK_EN.
package gb_stream_pkg;

    localparam logic [7:0] GBS_CMD_WR = 8'h00;
    localparam logic [7:0] GBS_CMD_RD = 8'h80;
    localparam logic [7:0] GBS_ACK    = 8'hA5;

    localparam int unsigned GBS_AW_DEF = 24;
    localparam int unsigned GBS_DW_DEF = 32;

    // Bytes needed to carry a field of the given bit width
    function automatic int unsigned gbs_bytes(input int unsigned bits);
        return bits / 8;
    endfunction

    localparam int unsigned GBS_AW_BYTES = gbs_bytes(GBS_AW_DEF);
    localparam int unsigned GBS_DW_BYTES = gbs_bytes(GBS_DW_DEF);

    // Error counter increment that sticks at 255
    function automatic logic [7:0] gbs_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    typedef enum logic [2:0] {
        GBS_IDLE,
        GBS_ADDR,
        GBS_DATA,
        GBS_WSTB,
        GBS_RSTB,
        GBS_RWAIT,
`ifdef GB_STREAM_WACK_EN
        GBS_TX,
        GBS_ACK
`else
        GBS_TX
`endif
    } gbs_state_t;

endpackage

// File: rtl/gb_stream_watchdog.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// pulses expire on the TIMEOUT-th such cycle.
module gb_stream_watchdog #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic gb_clk,
    input  logic gb_rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expire = en & ~clr & (cnt == CW'(TIMEOUT - 1));

    // Idle-cycle counter, restarted on clear or after firing
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gb_stream_master.sv
// Byte-stream host bridge mastering the ghostbus. Parses write/read command
// packets and returns read data (and, with GB_STREAM_WACK_EN defined, a 0xA5
// write acknowledge) on the outbound byte stream.
module gb_stream_master
    import gb_stream_pkg::*;
#(
    parameter int unsigned AW      = GBS_AW_DEF,
    parameter int unsigned DW      = GBS_DW_DEF,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic [7:0]    err_cnt
);

    localparam int unsigned AB = gbs_bytes(AW);
    localparam int unsigned DB = gbs_bytes(DW);

    gbs_state_t    state;
    logic          op_rd;
    logic [7:0]    bcnt;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] addr_sh;
    logic [DW-1:0] tx_sh;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] wdata_next;
    logic          rx_fire;
    logic          tx_fire;
    logic          wd_en;
    logic          wd_clr;
    logic          wd_expire;

    assign rx_fire    = rx_valid & rx_ready;
    assign tx_fire    = tx_valid & tx_ready;
    assign wd_en      = (state == GBS_ADDR) || (state == GBS_DATA);
    assign wd_clr     = rx_fire | ~wd_en;
    assign addr_next  = (addr_sh << 8) | AW'(rx_data);
    assign wdata_next = (gb_wdata << 8) | DW'(rx_data);

    gb_stream_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .gb_clk   (gb_clk),
        .gb_rst_n (gb_rst_n),
        .clr      (wd_clr),
        .en       (wd_en),
        .expire   (wd_expire)
    );

    // Packet parser and bus sequencer; rx_ready is registered alongside the
    // state so it is high exactly in IDLE/ADDR/DATA.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state    <= GBS_IDLE;
            op_rd    <= 1'b0;
            bcnt     <= '0;
            lat_cnt  <= '0;
            addr_sh  <= '0;
            tx_sh    <= '0;
            rx_ready <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            gb_addr  <= '0;
            gb_wdata <= '0;
            gb_wen   <= 1'b0;
            gb_rstb  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            gb_wen  <= 1'b0;
            gb_rstb <= 1'b0;
            case (state)
                GBS_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        if (rx_data == GBS_CMD_WR || rx_data == GBS_CMD_RD) begin
                            op_rd <= rx_data[7];
                            bcnt  <= '0;
                            state <= GBS_ADDR;
                        end else begin
                            err_cnt <= gbs_sat_inc(err_cnt);
                        end
                    end
                end
                GBS_ADDR: begin
                    if (wd_expire) begin
                        state   <= GBS_IDLE;
                        err_cnt <= gbs_sat_inc(err_cnt);
                    end else if (rx_fire) begin
                        addr_sh <= addr_next;
                        if (bcnt == 8'(AB - 1)) begin
                            bcnt    <= '0;
                            gb_addr <= addr_next;
                            if (op_rd) begin
                                gb_rstb  <= 1'b1;
                                rx_ready <= 1'b0;
                                state    <= GBS_RSTB;
                            end else begin
                                state <= GBS_DATA;
                            end
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                end
                GBS_DATA: begin
                    if (wd_expire) begin
                        state   <= GBS_IDLE;
                        err_cnt <= gbs_sat_inc(err_cnt);
                    end else if (rx_fire) begin
                        gb_wdata <= wdata_next;
                        if (bcnt == 8'(DB - 1)) begin
                            bcnt     <= '0;
                            gb_wen   <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= GBS_WSTB;
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                end
                GBS_WSTB: begin
`ifdef GB_STREAM_WACK_EN
                    tx_data  <= GBS_ACK;
                    tx_valid <= 1'b1;
                    state    <= GBS_ACK;
`else
                    rx_ready <= 1'b1;
                    state    <= GBS_IDLE;
`endif
                end
                GBS_RSTB: begin
                    lat_cnt <= 4'(RD_LAT);
                    state   <= GBS_RWAIT;
                end
                GBS_RWAIT: begin
                    // Capture on the cycle the counter steps from 1 to 0
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        tx_data  <= gb_rdata[DW-1 -: 8];
                        tx_sh    <= gb_rdata << 8;
                        tx_valid <= 1'b1;
                        bcnt     <= '0;
                        state    <= GBS_TX;
                    end
                end
                GBS_TX: begin
                    if (tx_fire) begin
                        if (bcnt == 8'(DB - 1)) begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= GBS_IDLE;
                        end else begin
                            tx_data <= tx_sh[DW-1 -: 8];
                            tx_sh   <= tx_sh << 8;
                            bcnt    <= bcnt + 8'd1;
                        end
                    end
                end
`ifdef GB_STREAM_WACK_EN
                GBS_ACK: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= GBS_IDLE;
                    end
                end
`endif
                default: begin
                    rx_ready <= 1'b0;
                    tx_valid <= 1'b0;
                    state    <= GBS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gb_stream_master.md
# gb_stream_master

Byte-stream host bridge that masters the ghostbus driven into `top` (`gb_clk`, `gb_addr[23:0]`, `gb_wdata[31:0]`, `gb_rdata[31:0]`, `gb_wen`, `gb_rstb`). It parses framed command packets from an upstream byte source such as a UART or FIFO, and issues single ghostbus writes or reads. It returns read data, and optionally write acknowledges, on an outbound byte stream. It sits directly upstream of the ghostbus slave hierarchy.

## Interface
Parameters:
- `AW`, 24: ghostbus address width. It must be a multiple of 8 and at most 32.
- `DW`, 32: ghostbus data width. It must be a multiple of 8.
- `RD_LAT`, 2: cycles from the `gb_rstb` pulse to valid `gb_rdata`. Range 1..15.
- `TIMEOUT`, 65535: idle cycles allowed between bytes of one packet before the parser aborts.

Ports (single clock; reset is asynchronous and active-low):
- `gb_clk` in 1: system clock.
- `gb_rst_n` in 1: async active-low reset.
- `rx_data` in 8: inbound byte.
- `rx_valid` in 1: inbound byte valid.
- `rx_ready` out 1: block accepts `rx_data`.
- `tx_data` out 8: outbound byte.
- `tx_valid` out 1: outbound byte valid.
- `tx_ready` in 1: sink accepts `tx_data`.
- `gb_addr` out AW: bus address.
- `gb_wdata` out DW: bus write data.
- `gb_wen` out 1: one-cycle write strobe.
- `gb_rstb` out 1: one-cycle read strobe.
- `gb_rdata` in DW: bus read data.
- `err_cnt` out 8: saturating count of discarded command bytes and timeouts.

## Operation
- Handshakes:
  - A byte transfers on `rx_valid & rx_ready`, or on `tx_valid & tx_ready`.
  - `tx_data` and `tx_valid` hold until the byte is accepted.
- Packet format:
  - Command byte: `0x00` = write, `0x80` = read.
  - Then AW/8 address bytes, MSB first.
  - A write then carries DW/8 data bytes, MSB first.
- States:
  - IDLE: `rx_ready`=1. On a byte: `0x00` or `0x80` latches the op and goes to ADDR. Any other byte is discarded, `err_cnt`+1, and the state stays IDLE.
  - ADDR: `rx_ready`=1. Shifts in address bytes. After the last byte: write goes to DATA, read goes to RSTB.
  - DATA: `rx_ready`=1. Shifts data bytes into `gb_wdata`. After the last byte, goes to WSTB.
  - WSTB: `gb_wen`=1 for exactly one cycle. Next state is ACK if the ack feature is compiled in, else IDLE.
  - RSTB: `gb_rstb`=1 for exactly one cycle. Loads the latency counter with RD_LAT, then goes to RWAIT.
  - RWAIT: the counter decrements to 0, then `gb_rdata` is captured into the tx shift register and the state goes to TX.
  - TX: emits DW/8 bytes, MSB first. Goes to IDLE after the last handshake.
  - ACK: emits `0xA5`. Goes to IDLE after the handshake.
- `rx_ready`=0 in WSTB, RSTB, RWAIT, TX and ACK. The block does not pipeline packets.
- `gb_addr` and `gb_wdata` hold their last values between transactions.
- Timeout:
  - In ADDR or DATA, a counter counts cycles without an rx handshake.
  - When the count reaches TIMEOUT, the state returns to IDLE, the partial packet is dropped with no bus strobe, and `err_cnt`+1.
  - The counter clears on every accepted byte.
- `err_cnt` saturates at 255. When an error and a saturated count coincide, the count holds.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `gb_addr`=0, `gb_wdata`=0, `gb_wen`=0, `gb_rstb`=0, `err_cnt`=0, state=IDLE.
- `rx_ready` rises the first cycle after reset deasserts.
- All outputs are registered.
- Write: `gb_wen` asserts the cycle after the last data byte is accepted.
- Read:
  - `gb_rstb` asserts the cycle after the last address byte is accepted.
  - `gb_rdata` is sampled RD_LAT cycles after the `gb_rstb` cycle.
  - `tx_valid` rises the following cycle.
- Reset mid-packet or mid-TX: all state clears immediately and the partial operation is lost. No strobe is emitted after reset.
- `tx_ready` held low stalls TX or ACK indefinitely. The timeout does not apply in TX or ACK.

## Configuration
- `GB_STREAM_WACK_EN`:
  - Defined: every completed write emits one ack byte `0xA5` after `gb_wen`.
  - Undefined: the ACK state is removed and writes return to IDLE with no outbound byte.

## Structure
- Package `gb_stream_pkg`:
  - Command codes `GBS_CMD_WR`=`0x00` and `GBS_CMD_RD`=`0x80`.
  - `GBS_ACK`=`0xA5`.
  - State enum typedef.
  - Byte-count localparams derived from AW and DW.
- Sub-module `gb_stream_watchdog`: the inter-byte timeout counter. It has clear and enable inputs and outputs a one-cycle expire pulse.

## Test plan
- Write: stream `00 00 01 23 DE AD BE EF` → one `gb_wen` cycle with `gb_addr`=`0x000123` and `gb_wdata`=`0xDEADBEEF`. With `GB_STREAM_WACK_EN`, `tx_data`=`0xA5` follows.
- Read:
  - Stimulus: stream `80 00 00 42`, with a model returning `0x12345678` at RD_LAT=2.
  - Response: `gb_rstb` pulses once, and TX emits `12 34 56 78`.
- Bad command: byte `0x7F` in IDLE → no strobe and `err_cnt`=1. A following valid write still completes.
- Timeout: stream `00 00 01`, then stall TIMEOUT cycles → return to IDLE, no `gb_wen`, and `err_cnt`+1.
- Backpressure:
  - Stimulus: a read with `tx_ready` low for 20 cycles per byte.
  - Response: bytes are stable until accepted, and `rx_ready`=0 throughout.
- Reset:
  - Stimulus: assert `gb_rst_n` low during the DATA phase of a write.
  - Response: outputs go to reset values and no `gb_wen` appears.
